// File: rtl/dispatch_queue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_queue_unit_pkg
// Desc     : Shared opcode encodings, widths and the RV32I head decoder.
// Revision : 1.0 - initial release
// ============================================================================
package dispatch_queue_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam int OPENUM_W  = 6;
    localparam int ZERO_ROB  = 0;

    // Loads and stores are kept contiguous so LB..SW selects the LSB path.
    typedef enum logic [OPENUM_W-1:0] {
        NOP, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } openum_t;

    typedef struct packed {
        openum_t              openum;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [31:0]          imm;
        logic                 is_jump;
        logic                 is_store;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] inst);
        decoded_t   d;
        logic [2:0] f3;
        logic [31:0] imm_i;
        f3    = inst[14:12];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        d     = '0;
        d.rd  = inst[11:7];
        d.rs1 = inst[19:15];
        d.rs2 = inst[24:20];
        case (inst[6:0])
            7'b0110111, 7'b0010111: begin
                d.openum = (inst[5]) ? LUI : AUIPC;
                d.imm    = {inst[31:12], 12'b0};
                d.rs1    = '0;
                d.rs2    = '0;
            end
            7'b1101111: begin
                d.openum  = JAL;
                d.imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                d.rs1     = '0;
                d.rs2     = '0;
                d.is_jump = 1'b1;
            end
            7'b1100111: begin
                d.openum  = (f3 == 3'b000) ? JALR : NOP;
                d.imm     = imm_i;
                d.rs2     = '0;
                d.is_jump = 1'b1;
            end
            7'b1100011: begin
                d.imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                d.rd      = '0;
                d.is_jump = 1'b1;
                case (f3)
                    3'b000:  d.openum = BEQ;
                    3'b001:  d.openum = BNE;
                    3'b100:  d.openum = BLT;
                    3'b101:  d.openum = BGE;
                    3'b110:  d.openum = BLTU;
                    3'b111:  d.openum = BGEU;
                    default: d.openum = NOP;
                endcase
            end
            7'b0000011: begin
                d.imm = imm_i;
                d.rs2 = '0;
                case (f3)
                    3'b000:  d.openum = LB;
                    3'b001:  d.openum = LH;
                    3'b010:  d.openum = LW;
                    3'b100:  d.openum = LBU;
                    3'b101:  d.openum = LHU;
                    default: d.openum = NOP;
                endcase
            end
            7'b0100011: begin
                d.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.rd       = '0;
                d.is_store = 1'b1;
                case (f3)
                    3'b000:  d.openum = SB;
                    3'b001:  d.openum = SH;
                    3'b010:  d.openum = SW;
                    default: d.openum = NOP;
                endcase
            end
            7'b0010011: begin
                d.imm = imm_i;
                d.rs2 = '0;
                case (f3)
                    3'b000:  d.openum = ADDI;
                    3'b010:  d.openum = SLTI;
                    3'b011:  d.openum = SLTIU;
                    3'b100:  d.openum = XORI;
                    3'b110:  d.openum = ORI;
                    3'b111:  d.openum = ANDI;
                    3'b001:  d.openum = SLLI;
                    default: d.openum = inst[30] ? SRAI : SRLI;
                endcase
            end
            7'b0110011: begin
                case (f3)
                    3'b000:  d.openum = inst[30] ? SUB : ADD;
                    3'b001:  d.openum = SLL;
                    3'b010:  d.openum = SLT;
                    3'b011:  d.openum = SLTU;
                    3'b100:  d.openum = XOR;
                    3'b101:  d.openum = inst[30] ? SRA : SRL;
                    3'b110:  d.openum = OR;
                    default: d.openum = AND;
                endcase
            end
            default: d.openum = NOP;
        endcase
        // Anything unrecognised becomes a clean all-zero NOP.
        if (d.openum == NOP) begin
            d = '0;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_queue_unit_operand_bypass.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_queue_unit_operand_bypass
// Desc     : Resolves one source operand from CDB, ROB readiness or regfile.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_queue_unit_operand_bypass
    import dispatch_queue_unit_pkg::*;
#(
    parameter int CDB_PORTS = 2,
    parameter int ROB_ID_W  = 4,
    parameter int DATA_W    = 32
) (
    input  logic [DATA_W-1:0]           reg_v,
    input  logic [ROB_ID_W-1:0]         reg_q,
    input  logic                        rob_ready,
    input  logic [DATA_W-1:0]           rob_data,
    input  logic [CDB_PORTS-1:0]        cdb_valid,
    input  logic [CDB_PORTS*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [CDB_PORTS*DATA_W-1:0] cdb_result,
    output logic [DATA_W-1:0]           v,
    output logic [ROB_ID_W-1:0]         q
);

    // Walk from the highest channel down so the lowest-index hit wins last.
    always_comb begin
        v = reg_v;
        q = reg_q;
        if (rob_ready) begin
            v = rob_data;
            q = ROB_ID_W'(ZERO_ROB);
        end
        for (int i = CDB_PORTS - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (reg_q != ROB_ID_W'(ZERO_ROB)) &&
                (cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == reg_q)) begin
                v = cdb_result[i*DATA_W +: DATA_W];
                q = ROB_ID_W'(ZERO_ROB);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_queue_unit
// Desc     : In-order instruction FIFO + decode + single-issue dispatch.
//            Optional issue/stall counters when DISPATCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_queue_unit
    import dispatch_queue_unit_pkg::*;
#(
    parameter int IQ_DEPTH  = 4,
    parameter int CDB_PORTS = 2,
    parameter int ROB_ID_W  = 4,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          if_valid,
    output logic                          if_ready,
    input  logic [DATA_W-1:0]             if_inst,
    input  logic [DATA_W-1:0]             if_pc,
    input  logic [DATA_W-1:0]             if_rollback_pc,
    input  logic                          if_pred_jump,
    input  logic                          rob_full,
    input  logic                          rs_full,
    input  logic                          lsb_full,
    input  logic [ROB_ID_W-1:0]           rob_alloc_id,
    output logic [REG_IDX_W-1:0]          rs1_to_reg,
    output logic [REG_IDX_W-1:0]          rs2_to_reg,
    input  logic [DATA_W-1:0]             V1_from_reg,
    input  logic [DATA_W-1:0]             V2_from_reg,
    input  logic [ROB_ID_W-1:0]           Q1_from_reg,
    input  logic [ROB_ID_W-1:0]           Q2_from_reg,
    output logic [ROB_ID_W-1:0]           Q1_to_rob,
    output logic [ROB_ID_W-1:0]           Q2_to_rob,
    input  logic                          Q1_ready_from_rob,
    input  logic                          Q2_ready_from_rob,
    input  logic [DATA_W-1:0]             rob_data1,
    input  logic [DATA_W-1:0]             rob_data2,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [CDB_PORTS*DATA_W-1:0]   cdb_result,
    input  logic                          rollback,
    output logic                          ena_to_rob,
    output logic                          ena_to_reg,
    output logic                          ena_to_rs,
    output logic                          ena_to_lsb,
    output openum_t                       out_openum,
    output logic [REG_IDX_W-1:0]          out_rd,
    output logic [DATA_W-1:0]             out_imm,
    output logic [DATA_W-1:0]             out_pc,
    output logic [DATA_W-1:0]             out_rollback_pc,
    output logic                          out_pred_jump,
    output logic                          out_is_jump,
    output logic                          out_is_store,
    output logic [DATA_W-1:0]             out_V1,
    output logic [DATA_W-1:0]             out_V2,
    output logic [ROB_ID_W-1:0]           out_Q1,
    output logic [ROB_ID_W-1:0]           out_Q2,
    output logic [ROB_ID_W-1:0]           out_rob_id
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]                   perf_issued,
    output logic [31:0]                   perf_stall
`endif
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]   r_inst_mem [IQ_DEPTH];
    logic [DATA_W-1:0]   r_pc_mem   [IQ_DEPTH];
    logic [DATA_W-1:0]   r_rbpc_mem [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] r_pred_mem;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    decoded_t            w_dec;
    logic                w_nonempty;
    logic                w_head_nop;
    logic                w_to_lsb;
    logic                w_target_full;
    logic                w_fire;
    logic                w_pop;
    logic                w_push;
    logic [DATA_W-1:0]   w_v1;
    logic [DATA_W-1:0]   w_v2;
    logic [ROB_ID_W-1:0] w_q1;
    logic [ROB_ID_W-1:0] w_q2;

    assign w_dec         = decode(r_inst_mem[r_head][31:0]);
    assign w_nonempty    = (r_count != '0);
    assign w_head_nop    = (w_dec.openum == NOP);
    assign w_to_lsb      = (w_dec.openum >= LB) && (w_dec.openum <= SW);
    assign w_target_full = w_to_lsb ? lsb_full : rs_full;
    assign w_fire        = rdy && !rollback && w_nonempty && !w_head_nop &&
                           !rob_full && !w_target_full;
    assign w_pop         = w_fire || (rdy && !rollback && w_nonempty && w_head_nop);
    // Count never exceeds IQ_DEPTH, so its MSB alone flags "full".
    assign if_ready      = !r_count[PTR_W] && !rollback;
    assign w_push        = if_valid && if_ready && rdy;

    assign rs1_to_reg = w_dec.rs1;
    assign rs2_to_reg = w_dec.rs2;
    assign Q1_to_rob  = Q1_from_reg;
    assign Q2_to_rob  = Q2_from_reg;

    dispatch_queue_unit_operand_bypass #(
        .CDB_PORTS (CDB_PORTS),
        .ROB_ID_W  (ROB_ID_W),
        .DATA_W    (DATA_W)
    ) u_bypass_op1 (
        .reg_v      (V1_from_reg),
        .reg_q      (Q1_from_reg),
        .rob_ready  (Q1_ready_from_rob),
        .rob_data   (rob_data1),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_result (cdb_result),
        .v          (w_v1),
        .q          (w_q1)
    );

    dispatch_queue_unit_operand_bypass #(
        .CDB_PORTS (CDB_PORTS),
        .ROB_ID_W  (ROB_ID_W),
        .DATA_W    (DATA_W)
    ) u_bypass_op2 (
        .reg_v      (V2_from_reg),
        .reg_q      (Q2_from_reg),
        .rob_ready  (Q2_ready_from_rob),
        .rob_data   (rob_data2),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_result (cdb_result),
        .v          (w_v2),
        .q          (w_q2)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_tail] <= if_inst;
            r_pc_mem[r_tail]   <= if_pc;
            r_rbpc_mem[r_tail] <= if_rollback_pc;
            r_pred_mem[r_tail] <= if_pred_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            ena_to_rob      <= 1'b0;
            ena_to_reg      <= 1'b0;
            ena_to_rs       <= 1'b0;
            ena_to_lsb      <= 1'b0;
            out_openum      <= NOP;
            out_rd          <= '0;
            out_imm         <= '0;
            out_pc          <= '0;
            out_rollback_pc <= '0;
            out_pred_jump   <= 1'b0;
            out_is_jump     <= 1'b0;
            out_is_store    <= 1'b0;
            out_V1          <= '0;
            out_V2          <= '0;
            out_Q1          <= '0;
            out_Q2          <= '0;
            out_rob_id      <= '0;
        end else if (rollback) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            ena_to_rob <= 1'b0;
            ena_to_reg <= 1'b0;
            ena_to_rs  <= 1'b0;
            ena_to_lsb <= 1'b0;
        end else begin
            ena_to_rob <= w_fire;
            ena_to_reg <= w_fire;
            ena_to_rs  <= w_fire && !w_to_lsb;
            ena_to_lsb <= w_fire && w_to_lsb;
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_fire) begin
                out_openum      <= w_dec.openum;
                out_rd          <= w_dec.rd;
                out_imm         <= DATA_W'($signed(w_dec.imm));
                out_pc          <= r_pc_mem[r_head];
                out_rollback_pc <= r_rbpc_mem[r_head];
                out_pred_jump   <= r_pred_mem[r_head];
                out_is_jump     <= w_dec.is_jump;
                out_is_store    <= w_dec.is_store;
                out_V1          <= w_v1;
                out_V2          <= w_v2;
                out_Q1          <= w_q1;
                out_Q2          <= w_q2;
                out_rob_id      <= rob_alloc_id;
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_fire) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (rdy && !rollback && w_nonempty && !w_head_nop && !w_fire) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_queue_unit
// Desc     : Directed + random stimulus against a queue-based dispatch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue_unit;
    import dispatch_queue_unit_pkg::*;

    localparam int IQ_DEPTH  = 4;
    localparam int CDB_PORTS = 2;
    localparam int ROB_ID_W  = 4;
    localparam int DATA_W    = 32;

    logic clk = 1'b0;
    logic rst, rdy, if_valid, if_ready, if_pred_jump;
    logic [DATA_W-1:0] if_inst, if_pc, if_rollback_pc;
    logic rob_full, rs_full, lsb_full, rollback;
    logic [ROB_ID_W-1:0] rob_alloc_id;
    logic [4:0] rs1_to_reg, rs2_to_reg;
    logic [DATA_W-1:0] V1_from_reg, V2_from_reg, rob_data1, rob_data2;
    logic [ROB_ID_W-1:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob;
    logic Q1_ready_from_rob, Q2_ready_from_rob;
    logic [CDB_PORTS-1:0] cdb_valid;
    logic [CDB_PORTS*ROB_ID_W-1:0] cdb_rob_id;
    logic [CDB_PORTS*DATA_W-1:0] cdb_result;
    logic ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb;
    openum_t out_openum;
    logic [4:0] out_rd;
    logic [DATA_W-1:0] out_imm, out_pc, out_rollback_pc, out_V1, out_V2;
    logic out_pred_jump, out_is_jump, out_is_store;
    logic [ROB_ID_W-1:0] out_Q1, out_Q2, out_rob_id;
`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_issued, perf_stall;
    int unsigned exp_issued = 0, exp_stall = 0;
`endif

    always #5 clk = ~clk;

    dispatch_queue_unit #(
        .IQ_DEPTH(IQ_DEPTH), .CDB_PORTS(CDB_PORTS), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .if_rollback_pc(if_rollback_pc), .if_pred_jump(if_pred_jump),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_alloc_id(rob_alloc_id),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
        .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
        .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
        .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
        .rob_data1(rob_data1), .rob_data2(rob_data2),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .rollback(rollback),
        .ena_to_rob(ena_to_rob), .ena_to_reg(ena_to_reg), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
        .out_openum(out_openum), .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
        .out_rollback_pc(out_rollback_pc), .out_pred_jump(out_pred_jump),
        .out_is_jump(out_is_jump), .out_is_store(out_is_store),
        .out_V1(out_V1), .out_V2(out_V2), .out_Q1(out_Q1), .out_Q2(out_Q2), .out_rob_id(out_rob_id)
`ifdef DISPATCH_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] inst, pc, rbpc, imm;
        logic        pred, is_jump, is_store, is_mem, has_rs1, has_rs2;
        openum_t     op;
        logic [4:0]  rd, rs1, rs2;
    } entry_t;

    entry_t fifo[$];
    entry_t cur;
    logic [ROB_ID_W-1:0] cdb_id_arr  [CDB_PORTS];
    logic [DATA_W-1:0]   cdb_res_arr [CDB_PORTS];

    int n_checks = 0;
    int n_err    = 0;

    logic exp_rob = 0, exp_reg = 0, exp_rs = 0, exp_lsb = 0;
    openum_t exp_op = NOP;
    logic [4:0] exp_rd = '0;
    logic [31:0] exp_imm = '0, exp_pc = '0, exp_rbpc = '0, exp_V1 = '0, exp_V2 = '0;
    logic exp_pred = 0, exp_jump = 0, exp_store = 0;
    logic [ROB_ID_W-1:0] exp_Q1 = '0, exp_Q2 = '0, exp_rid = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Builds an instruction from its fields, so expectations come from the ISA encoding.
    function automatic entry_t make_entry(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] rnd);
        entry_t e;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        i12 = rnd[11:0];
        b13 = {rnd[12:1], 1'b0};
        j21 = {rnd[20:1], 1'b0};
        e.pc = 32'h0; e.rbpc = 32'h0; e.pred = 1'b0;
        e.op = NOP; e.inst = 32'h0; e.imm = 32'h0; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.is_jump = 0; e.is_store = 0; e.is_mem = 0; e.has_rs1 = 0; e.has_rs2 = 0;
        case (kind)
            0: begin e.op = ADDI; e.inst = {i12, rs1, 3'b000, rd, 7'b0010011};
                     e.imm = {{20{i12[11]}}, i12}; e.has_rs1 = 1; end
            1: begin e.op = ADD; e.inst = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
                     e.has_rs1 = 1; e.has_rs2 = 1; end
            2: begin e.op = LW; e.inst = {i12, rs1, 3'b010, rd, 7'b0000011};
                     e.imm = {{20{i12[11]}}, i12}; e.is_mem = 1; e.has_rs1 = 1; end
            3: begin e.op = SW; e.inst = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
                     e.imm = {{20{i12[11]}}, i12}; e.rd = 0; e.is_mem = 1; e.is_store = 1;
                     e.has_rs1 = 1; e.has_rs2 = 1; end
            4: begin e.op = BEQ; e.inst = {b13[12], b13[10:5], rs2, rs1, 3'b000, b13[4:1], b13[11], 7'b1100011};
                     e.imm = {{19{b13[12]}}, b13}; e.rd = 0; e.is_jump = 1; e.has_rs1 = 1; e.has_rs2 = 1; end
            5: begin e.op = JAL; e.inst = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'b1101111};
                     e.imm = {{11{j21[20]}}, j21}; e.is_jump = 1; end
            6: begin e.op = LUI; e.inst = {rnd[31:12], rd, 7'b0110111}; e.imm = {rnd[31:12], 12'b0}; end
            default: ;
        endcase
        return e;
    endfunction

    // First matching CDB channel (non-zero tag), then ROB readiness, then regfile.
    function automatic logic [DATA_W+ROB_ID_W-1:0] resolve(input logic [ROB_ID_W-1:0] q,
            input logic [DATA_W-1:0] v, input logic rr, input logic [DATA_W-1:0] rdat);
        if (q != 0) begin
            for (int i = 0; i < CDB_PORTS; i++) begin
                if (cdb_valid[i] && cdb_id_arr[i] == q) return {cdb_res_arr[i], ROB_ID_W'(0)};
            end
        end
        if (rr) return {rdat, ROB_ID_W'(0)};
        return {v, q};
    endfunction

    task automatic check_regs();
        chk("ena_to_rob", ena_to_rob, exp_rob);
        chk("ena_to_reg", ena_to_reg, exp_reg);
        chk("ena_to_rs", ena_to_rs, exp_rs);
        chk("ena_to_lsb", ena_to_lsb, exp_lsb);
        chk("out_openum", out_openum, exp_op);
        chk("out_rd", out_rd, exp_rd);
        chk("out_imm", out_imm, exp_imm);
        chk("out_pc", out_pc, exp_pc);
        chk("out_rollback_pc", out_rollback_pc, exp_rbpc);
        chk("out_pred_jump", out_pred_jump, exp_pred);
        chk("out_is_jump", out_is_jump, exp_jump);
        chk("out_is_store", out_is_store, exp_store);
        chk("out_V1", out_V1, exp_V1);
        chk("out_V2", out_V2, exp_V2);
        chk("out_Q1", out_Q1, exp_Q1);
        chk("out_Q2", out_Q2, exp_Q2);
        chk("out_rob_id", out_rob_id, exp_rid);
`ifdef DISPATCH_PERF_EN
        chk("perf_issued", perf_issued, exp_issued);
        chk("perf_stall", perf_stall, exp_stall);
`endif
    endtask

    task automatic cycle();
        entry_t h;
        logic fire, pop, push;
        logic [DATA_W+ROB_ID_W-1:0] r1, r2;
        if_inst = cur.inst; if_pc = cur.pc; if_rollback_pc = cur.rbpc; if_pred_jump = cur.pred;
        for (int i = 0; i < CDB_PORTS; i++) begin
            cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] = cdb_id_arr[i];
            cdb_result[i*DATA_W +: DATA_W]     = cdb_res_arr[i];
        end
        @(negedge clk);
        chk("if_ready", if_ready, (fifo.size() < IQ_DEPTH) && !rollback);
        chk("Q1_to_rob", Q1_to_rob, Q1_from_reg);
        chk("Q2_to_rob", Q2_to_rob, Q2_from_reg);
        if (fifo.size() != 0 && fifo[0].has_rs1) chk("rs1_to_reg", rs1_to_reg, fifo[0].rs1);
        if (fifo.size() != 0 && fifo[0].has_rs2) chk("rs2_to_reg", rs2_to_reg, fifo[0].rs2);
        fire = 0; pop = 0;
        push = rdy && if_valid && !rollback && (fifo.size() < IQ_DEPTH);
        h = cur;
        if (rollback) begin
            fifo.delete();
        end else if (rdy && fifo.size() != 0) begin
            h = fifo[0];
            if (h.op == NOP) pop = 1;
            else if (!rob_full && !(h.is_mem ? lsb_full : rs_full)) begin fire = 1; pop = 1; end
`ifdef DISPATCH_PERF_EN
            if (h.op != NOP && !fire) exp_stall++;
`endif
        end
        r1 = resolve(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, rob_data1);
        r2 = resolve(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, rob_data2);
        @(posedge clk);
        if (pop) void'(fifo.pop_front());
        if (push) fifo.push_back(cur);
        exp_rob = fire; exp_reg = fire; exp_rs = fire && !h.is_mem; exp_lsb = fire && h.is_mem;
        if (fire) begin
            exp_op = h.op; exp_rd = h.rd; exp_imm = h.imm; exp_pc = h.pc; exp_rbpc = h.rbpc;
            exp_pred = h.pred; exp_jump = h.is_jump; exp_store = h.is_store;
            {exp_V1, exp_Q1} = r1; {exp_V2, exp_Q2} = r2; exp_rid = rob_alloc_id;
`ifdef DISPATCH_PERF_EN
            exp_issued++;
`endif
        end
        #1;
        check_regs();
    endtask

    task automatic set_idle();
        rdy = 1; rollback = 0; if_valid = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
        rob_alloc_id = 0; V1_from_reg = 0; V2_from_reg = 0; Q1_from_reg = 0; Q2_from_reg = 0;
        Q1_ready_from_rob = 0; Q2_ready_from_rob = 0; rob_data1 = 0; rob_data2 = 0; cdb_valid = 0;
        for (int i = 0; i < CDB_PORTS; i++) begin cdb_id_arr[i] = 0; cdb_res_arr[i] = 0; end
    endtask

    initial begin
        set_idle();
        cur = make_entry(7, 0, 0, 0, 0);
        if_inst = 0; if_pc = 0; if_rollback_pc = 0; if_pred_jump = 0;
        cdb_rob_id = 0; cdb_result = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_regs();

        // ADDI x1,x0,5 issues on the edge after its push, to RS.
        cur = make_entry(0, 5'd1, 5'd0, 5'd0, 32'd5); cur.pc = 32'h0; cur.rbpc = 32'h4;
        if_valid = 1; rob_alloc_id = 3;
        cycle();
        if_valid = 0;
        cycle();
        chk("first_issue_imm", out_imm, 32'd5);
        chk("first_issue_rob_id", out_rob_id, 4'd3);
        cycle();

        // Fill past capacity while the RS is full, then drain.
        rs_full = 1; if_valid = 1;
        for (int k = 0; k < 5; k++) begin
            cur = make_entry(1, 5'(k + 1), 5'(k), 5'(k + 2), 0); cur.pc = 32'(16 * (k + 1));
            cycle();
        end
        if_valid = 0; rs_full = 0;
        repeat (5) cycle();

        // CDB priority: channel 0 wins over channel 1; then ROB readiness.
        cur = make_entry(0, 5'd2, 5'd3, 5'd0, 32'h10); if_valid = 1;
        Q1_from_reg = 2; cdb_valid = 2'b11;
        cdb_id_arr[0] = 2; cdb_res_arr[0] = 32'hAA; cdb_id_arr[1] = 2; cdb_res_arr[1] = 32'hBB;
        cycle();
        if_valid = 0;
        cycle();
        chk("cdb0_priority_V1", out_V1, 32'hAA);
        cdb_valid = 0; Q1_ready_from_rob = 1; rob_data1 = 32'hCC; if_valid = 1;
        cycle();
        if_valid = 0;
        cycle();
        chk("rob_ready_V1", out_V1, 32'hCC);
        set_idle();

        // Blocked SW holds the ALU op behind it; order preserved on release.
        lsb_full = 1; if_valid = 1;
        cur = make_entry(3, 0, 5'd4, 5'd5, 32'h20); cycle();
        cur = make_entry(1, 5'd6, 5'd4, 5'd5, 0); cycle();
        if_valid = 0;
        repeat (2) cycle();
        lsb_full = 0;
        repeat (3) cycle();

        // Rollback with 3 queued drops everything, including the same-cycle push.
        rs_full = 1; if_valid = 1;
        for (int k = 0; k < 3; k++) begin cur = make_entry(1, 5'(k), 5'(k), 5'(k), 0); cycle(); end
        rollback = 1; cur = make_entry(0, 5'd9, 5'd9, 5'd0, 32'h77);
        cycle();
        rollback = 0; if_valid = 0; rs_full = 0;
        repeat (3) cycle();

        // Random traffic.
        repeat (600) begin
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 29) == 0);
            if_valid = ($urandom_range(0, 2) != 0);
            rob_full = ($urandom_range(0, 5) == 0);
            rs_full = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            rob_alloc_id = ROB_ID_W'($urandom);
            V1_from_reg = $urandom; V2_from_reg = $urandom;
            Q1_from_reg = ROB_ID_W'($urandom_range(0, 3)); Q2_from_reg = ROB_ID_W'($urandom_range(0, 3));
            Q1_ready_from_rob = ($urandom_range(0, 2) == 0); Q2_ready_from_rob = ($urandom_range(0, 2) == 0);
            rob_data1 = $urandom; rob_data2 = $urandom;
            cdb_valid = CDB_PORTS'($urandom);
            for (int i = 0; i < CDB_PORTS; i++) begin
                cdb_id_arr[i] = ROB_ID_W'($urandom_range(0, 3)); cdb_res_arr[i] = $urandom;
            end
            cur = make_entry(int'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            cur.pc = $urandom; cur.rbpc = $urandom; cur.pred = 1'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
